audio_i2s_rx: RTL

//  Codec-side front end for the ANC datapath. Deserialises two I2S ADC lines into ref/en1/en2 16-bit samples.

---
 rtl/audio_i2s_rx.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/audio_i2s_rx.sv
// audio_i2s_rx
//   Codec-side I2S receiver for the ANC datapath. Two ADC lines are
//   deserialised into three signed samples (ref/en1/en2). One aligned sample
//   set is presented per audio frame, together with a 1-clk audio_rx_down
//   strobe. BCLK, LRCK and ADCDAT are asynchronous to clk. They are
//   synchronised and edge-detected in the clk domain, which requires
//   clk >= 8x BCLK.
//
//   Optional feature macro: AUDIO_RX_LJ_EN
//     defined     : left-justified framing (MSB on the first BCLK after LRCK)
//     not defined : standard I2S framing (MSB one BCLK after the LRCK edge)
//
// Ports
//   clk            in   system clock
//   rst_n          in   synchronous active-low reset
//   i2s_bclk       in   codec bit clock (async)
//   i2s_lrck       in   codec word clock (async), 0 = left slot, 1 = right slot
//   i2s_adcdat0    in   ADC line 0: left = reference xn, right = error en1
//   i2s_adcdat1    in   ADC line 1: left = error en2, right = ignored
//   audio_ref_o    out  signed xn sample, held until the next frame
//   audio_en1_o    out  signed en1 sample, held
//   audio_en2_o    out  signed en2 sample, held
//   audio_rx_down  out  1-clk strobe, new ref/en1/en2 valid this cycle
//   frame_err      out  1-clk strobe, a slot ended short and the frame was dropped
//   frame_cnt      out  delivered-frame counter, wraps 4095 -> 0
module audio_i2s_rx #(
  parameter int DATA_W   = 16,
  parameter int SLOT_W   = 32,
  parameter int SYNC_STG = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i2s_bclk,
  input  logic                     i2s_lrck,
  input  logic                     i2s_adcdat0,
  input  logic                     i2s_adcdat1,
  output logic signed [DATA_W-1:0] audio_ref_o,
  output logic signed [DATA_W-1:0] audio_en1_o,
  output logic signed [DATA_W-1:0] audio_en2_o,
  output logic                     audio_rx_down,
  output logic                     frame_err,
  output logic [11:0]              frame_cnt
);

  // Slot bit index of the MSB. I2S framing delays the MSB by one BCLK.
`ifdef AUDIO_RX_LJ_EN
  localparam int FIRST_BIT = 0;
`else
  localparam int FIRST_BIT = 1;
`endif
  localparam logic [5:0] FIRST_B = 6'(FIRST_BIT);
  localparam logic [5:0] LAST_B  = 6'(FIRST_BIT + DATA_W - 1);
  localparam logic [5:0] DATA_B  = 6'(DATA_W);

  if (SLOT_W < DATA_W + 1 || SLOT_W > 64) begin : g_bad_slot_w
    $error("audio_i2s_rx: SLOT_W must lie in DATA_W+1..64");
  end

  typedef enum logic [1:0] {ST_SYNC, ST_LEFT, ST_RIGHT} state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic [SYNC_STG-1:0] r_bclk_s, r_lrck_s, r_d0_s, r_d1_s;
  logic                r_bclk_q, r_lrck_q;
  logic [5:0]          r_bit_cnt;
  logic [5:0]          w_cnt_base;
  logic [5:0]          w_idx;
  logic [DATA_W-1:0]   r_sh0_l, r_sh1_l, r_sh0_r;
  logic                w_bclk_rise, w_lrck_rise, w_lrck_fall;
  logic                w_slot_full, w_err, w_cap, w_last;
  logic                w_d0, w_d1;

  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v == 6'd63) ? v : v + 6'd1;
  endfunction

  assign w_d0        = r_d0_s[SYNC_STG-1];
  assign w_d1        = r_d1_s[SYNC_STG-1];
  assign w_bclk_rise =  r_bclk_s[SYNC_STG-1] & ~r_bclk_q;
  assign w_lrck_rise =  r_lrck_s[SYNC_STG-1] & ~r_lrck_q;
  assign w_lrck_fall = ~r_lrck_s[SYNC_STG-1] &  r_lrck_q;
  assign w_slot_full = (r_bit_cnt > LAST_B);

  // LRCK edges are resolved first, so a BCLK rise in the same clk is
  // processed against the new slot with the counter already restarted.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_base = r_bit_cnt;
    w_err      = 1'b0;
    case (r_state)
      ST_SYNC: begin
        if (w_lrck_fall) begin
          w_state_nx = ST_LEFT;
          w_cnt_base = '0;
        end
      end
      ST_LEFT: begin
        if (w_lrck_rise) begin
          w_cnt_base = '0;
          if (w_slot_full) begin
            w_state_nx = ST_RIGHT;
          end else begin
            w_state_nx = ST_SYNC;
            w_err      = 1'b1;
          end
        end else if (w_lrck_fall) begin
          w_cnt_base = '0;
        end
      end
      ST_RIGHT: begin
        if (w_lrck_fall) begin
          w_state_nx = ST_LEFT;
          w_cnt_base = '0;
          w_err      = ~w_slot_full;
        end
      end
      default: w_state_nx = ST_SYNC;
    endcase
  end

  // Index relative to the MSB position; the wrap of the 6-bit subtraction
  // makes the I2S delay bit fall outside the capture window.
  assign w_idx  = w_cnt_base - FIRST_B;
  assign w_cap  = w_bclk_rise && (w_state_nx != ST_SYNC) && (w_idx < DATA_B);
  assign w_last = w_cap && (w_idx == DATA_B - 6'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bclk_s      <= '0;
      r_lrck_s      <= '0;
      r_d0_s        <= '0;
      r_d1_s        <= '0;
      r_bclk_q      <= 1'b0;
      r_lrck_q      <= 1'b0;
      r_state       <= ST_SYNC;
      r_bit_cnt     <= '0;
      r_sh0_l       <= '0;
      r_sh1_l       <= '0;
      r_sh0_r       <= '0;
      audio_ref_o   <= '0;
      audio_en1_o   <= '0;
      audio_en2_o   <= '0;
      audio_rx_down <= 1'b0;
      frame_err     <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      r_bclk_s      <= (r_bclk_s << 1) | SYNC_STG'(i2s_bclk);
      r_lrck_s      <= (r_lrck_s << 1) | SYNC_STG'(i2s_lrck);
      r_d0_s        <= (r_d0_s << 1)   | SYNC_STG'(i2s_adcdat0);
      r_d1_s        <= (r_d1_s << 1)   | SYNC_STG'(i2s_adcdat1);
      r_bclk_q      <= r_bclk_s[SYNC_STG-1];
      r_lrck_q      <= r_lrck_s[SYNC_STG-1];
      r_state       <= w_state_nx;
      frame_err     <= w_err;
      audio_rx_down <= 1'b0;

      if (w_state_nx == ST_SYNC) begin
        r_bit_cnt <= '0;
      end else if (w_bclk_rise) begin
        r_bit_cnt <= sat_inc(w_cnt_base);
      end else begin
        r_bit_cnt <= w_cnt_base;
      end

      if (w_cap && (w_state_nx == ST_LEFT)) begin
        r_sh0_l <= DATA_W'({r_sh0_l, w_d0});
        r_sh1_l <= DATA_W'({r_sh1_l, w_d1});
      end
      if (w_cap && (w_state_nx == ST_RIGHT)) begin
        r_sh0_r <= DATA_W'({r_sh0_r, w_d0});
      end

      // The final right-slot bit is folded in directly so all three samples
      // update together with the strobe.
      if (w_last && (w_state_nx == ST_RIGHT)) begin
        audio_ref_o   <= r_sh0_l;
        audio_en1_o   <= DATA_W'({r_sh0_r, w_d0});
        audio_en2_o   <= r_sh1_l;
        audio_rx_down <= 1'b1;
        frame_cnt     <= frame_cnt + 12'd1;
      end
    end
  end

endmodule
